// File: rtl/m9_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// m9_access_arbiter_if
//
// Bundles every non-clock/reset signal of the M9 access arbiter.
//   Blender side : bl_read_req, bl_write_req, bl_addr, bl_wdata -> arbiter
//                  bl_ack, bl_rdata                             <- arbiter
//   Frame control: frame_ready -> arbiter; flush_busy, flush_done <- arbiter
//   M9 memory    : m9_addr, m9_read, m9_write, m9_wdata <- arbiter
//                  m9_rdata -> arbiter
//   SD_RAM       : sd_write, sd_wdata, sd_address <- arbiter
//                  sd_ready -> arbiter
//
// Modports:
//   slave  - the arbiter itself (serves blender and frame requests)
//   master - the surrounding system (blender, M9 RAM, SD_RAM, frame source)
// ---------------------------------------------------------------------------
interface m9_access_arbiter_if;

  // blender access port
  logic        bl_read_req;
  logic        bl_write_req;
  logic [7:0]  bl_addr;
  logic [23:0] bl_wdata;
  logic        bl_ack;
  logic [23:0] bl_rdata;

  // frame flush control
  logic        frame_ready;
  logic        flush_busy;
  logic        flush_done;

  // M9 frame-buffer memory
  logic [7:0]  m9_addr;
  logic        m9_read;
  logic        m9_write;
  logic [31:0] m9_wdata;
  logic [31:0] m9_rdata;

  // SD_RAM write port
  logic        sd_write;
  logic        sd_ready;
  logic [15:0] sd_wdata;
  logic [31:0] sd_address;

  modport slave (
    input  bl_read_req,
    input  bl_write_req,
    input  bl_addr,
    input  bl_wdata,
    output bl_ack,
    output bl_rdata,
    input  frame_ready,
    output flush_busy,
    output flush_done,
    output m9_addr,
    output m9_read,
    output m9_write,
    output m9_wdata,
    input  m9_rdata,
    output sd_write,
    input  sd_ready,
    output sd_wdata,
    output sd_address
  );

  modport master (
    output bl_read_req,
    output bl_write_req,
    output bl_addr,
    output bl_wdata,
    input  bl_ack,
    input  bl_rdata,
    output frame_ready,
    input  flush_busy,
    input  flush_done,
    input  m9_addr,
    input  m9_read,
    input  m9_write,
    input  m9_wdata,
    output m9_rdata,
    input  sd_write,
    output sd_ready,
    input  sd_wdata,
    input  sd_address
  );

endinterface

// File: rtl/m9_access_arbiter.sv
// ---------------------------------------------------------------------------
// m9_access_arbiter
//
// Shares the single-port M9 frame buffer between the alpha blender and the
// frame flush engine. A frame_ready pulse schedules a flush that copies every
// pixel (24-bit RGB888 stored in a 32-bit word) to SD_RAM as RGB565, one
// pixel per SD handshake. While a flush is running, blender requests wait.
//
// Parameters:
//   NUM_PIXELS - pixels in one frame buffer (2..256)
//   SD_BASE    - SD_RAM byte address of pixel 0
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - m9_access_arbiter_if.slave (blender, frame, M9 and SD signals)
//
// All outputs come straight from flops. Strobes are loaded on the edge that
// enters the state that owns them, so they are visible for exactly that
// state's cycle.
// ---------------------------------------------------------------------------
module m9_access_arbiter #(
  parameter int          NUM_PIXELS = 256,
  parameter logic [31:0] SD_BASE    = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  m9_access_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BL_WR   = 3'd1,
    BL_RD   = 3'd2,
    BL_CAP  = 3'd3,
    FL_RD   = 3'd4,
    FL_CAP  = 3'd5,
    FL_WR   = 3'd6,
    FL_DONE = 3'd7
  } state_e;

  localparam logic [7:0] LAST_PIX = 8'(NUM_PIXELS - 1);

  // SD byte address of a pixel: two bytes per RGB565 pixel, wraps mod 2^32.
  function automatic logic [31:0] pix_byte_addr(input logic [7:0] pix);
    return SD_BASE + {23'd0, pix, 1'b0};
  endfunction

  state_e      state_r;
  logic [7:0]  pix_cnt_r;
  logic        flush_pending_r;

  logic        bl_ack_r;
  logic [23:0] bl_rdata_r;
  logic [7:0]  m9_addr_r;
  logic        m9_read_r;
  logic        m9_write_r;
  logic [31:0] m9_wdata_r;
  logic        sd_write_r;
  logic [15:0] sd_wdata_r;
  logic [31:0] sd_address_r;
  logic        flush_busy_r;
  logic        flush_done_r;

  logic        flush_req_s;
  logic        bl_accept_ok_s;
  logic        unused_rdata_s;

  // A frame_ready arriving in the same cycle the FSM sits in IDLE must still
  // beat a blender request, so the raw pulse is folded into the flush request.
  assign flush_req_s    = flush_pending_r | (bus.frame_ready & ~flush_busy_r);
  // bl_ack from a read is visible while the FSM is already back in IDLE; do
  // not take the still-raised request of the access just acknowledged.
  assign bl_accept_ok_s = ~bl_ack_r;
  // The alpha byte of an M9 word is never used.
  assign unused_rdata_s = ^bus.m9_rdata[31:24];

  // Arbiter FSM: state, pixel counter, pending-flush flag and all outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      pix_cnt_r       <= 8'd0;
      flush_pending_r <= 1'b0;
      bl_ack_r        <= 1'b0;
      bl_rdata_r      <= 24'd0;
      m9_addr_r       <= 8'd0;
      m9_read_r       <= 1'b0;
      m9_write_r      <= 1'b0;
      m9_wdata_r      <= 32'd0;
      sd_write_r      <= 1'b0;
      sd_wdata_r      <= 16'd0;
      sd_address_r    <= 32'd0;
      flush_busy_r    <= 1'b0;
      flush_done_r    <= 1'b0;
    end else begin
      // single-cycle pulses fall back to 0 unless the next state reloads them
      bl_ack_r     <= 1'b0;
      m9_read_r    <= 1'b0;
      m9_write_r   <= 1'b0;
      flush_done_r <= 1'b0;

      // latch one frame request; repeats while one is queued or running are dropped
      if (bus.frame_ready && !flush_busy_r && !flush_pending_r) begin
        flush_pending_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (flush_req_s) begin
            state_r         <= FL_RD;
            pix_cnt_r       <= 8'd0;
            flush_busy_r    <= 1'b1;
            flush_pending_r <= 1'b0;
            m9_read_r       <= 1'b1;
            m9_addr_r       <= 8'd0;
          end else if (bus.bl_write_req && bl_accept_ok_s) begin
            // write wins over a simultaneous read; the read stays pending
            state_r    <= BL_WR;
            m9_write_r <= 1'b1;
            m9_addr_r  <= bus.bl_addr;
            m9_wdata_r <= {8'h00, bus.bl_wdata};
            bl_ack_r   <= 1'b1;
          end else if (bus.bl_read_req && bl_accept_ok_s) begin
            state_r   <= BL_RD;
            m9_read_r <= 1'b1;
            m9_addr_r <= bus.bl_addr;
          end else begin
            state_r <= IDLE;
          end
        end

        BL_WR: begin
          state_r <= IDLE;
        end

        BL_RD: begin
          // M9 returns the word during the next cycle
          state_r <= BL_CAP;
        end

        BL_CAP: begin
          bl_rdata_r <= bus.m9_rdata[23:0];
          bl_ack_r   <= 1'b1;
          state_r    <= IDLE;
        end

        FL_RD: begin
          state_r <= FL_CAP;
        end

        FL_CAP: begin
          // RGB888 -> RGB565 by keeping the top bits of each channel
          sd_wdata_r   <= {bus.m9_rdata[23:19], bus.m9_rdata[15:10], bus.m9_rdata[7:3]};
          sd_address_r <= pix_byte_addr(pix_cnt_r);
          sd_write_r   <= 1'b1;
          state_r      <= FL_WR;
        end

        FL_WR: begin
          // request, data and address hold until SD takes them
          if (sd_write_r && bus.sd_ready) begin
            sd_write_r <= 1'b0;
            if (pix_cnt_r == LAST_PIX) begin
              flush_done_r <= 1'b1;
              state_r      <= FL_DONE;
            end else begin
              pix_cnt_r <= pix_cnt_r + 8'd1;
              m9_read_r <= 1'b1;
              m9_addr_r <= pix_cnt_r + 8'd1;
              state_r   <= FL_RD;
            end
          end else begin
            state_r <= FL_WR;
          end
        end

        FL_DONE: begin
          flush_busy_r <= 1'b0;
          state_r      <= IDLE;
        end

        default: begin
          sd_write_r   <= 1'b0;
          flush_busy_r <= 1'b0;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.bl_ack     = bl_ack_r;
  assign bus.bl_rdata   = bl_rdata_r;
  assign bus.m9_addr    = m9_addr_r;
  assign bus.m9_read    = m9_read_r;
  assign bus.m9_write   = m9_write_r;
  assign bus.m9_wdata   = m9_wdata_r;
  assign bus.sd_write   = sd_write_r;
  assign bus.sd_wdata   = sd_wdata_r;
  assign bus.sd_address = sd_address_r;
  assign bus.flush_busy = flush_busy_r;
  assign bus.flush_done = flush_done_r;

endmodule

// File: doc/m9_access_arbiter.md
M9_ACCESS_ARBITER -- requirements
Module: m9_access_arbiter

Interface
REQ-001 Parameter NUM_PIXELS, default 256, number of pixels in one frame buffer; legal range 2..256.
REQ-002 Parameter SD_BASE, default 32'h0000_0000, SD_RAM byte address of pixel 0.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 bl_read_req  in  1  alpha-blender read request; held high until bl_ack.
REQ-006 bl_write_req  in  1  alpha-blender write request; held high until bl_ack.
REQ-007 bl_addr  in  8  pixel number for a blender access.
REQ-008 bl_wdata  in  24  {r,g,b} write pixel.
REQ-009 bl_ack  out  1  one-cycle pulse; blender access completed.
REQ-010 bl_rdata  out  24  {r,g,b} read pixel; valid while bl_ack is high for a read.
REQ-011 frame_ready  in  1  single-cycle pulse; frame complete, flush to SD_RAM.
REQ-012 m9_addr  out  8  M9 word address.
REQ-013 m9_read  out  1  M9 read strobe; data returned on m9_rdata exactly 1 cycle later.
REQ-014 m9_write  out  1  M9 write strobe.
REQ-015 m9_wdata  out  32  M9 write data.
REQ-016 m9_rdata  in  32  M9 read data.
REQ-017 sd_write  out  1  SD write request; held until sd_ready.
REQ-018 sd_ready  in  1  SD accepts write this cycle when high together with sd_write.
REQ-019 sd_wdata  out  16  RGB565 pixel.
REQ-020 sd_address  out  32  SD byte address.
REQ-021 flush_busy  out  1  high from flush start until flush_done.
REQ-022 flush_done  out  1  one-cycle pulse; last pixel accepted by SD.

Function
REQ-023 All outputs registered; FSM states IDLE, BL_WR, BL_RD, BL_CAP, FL_RD, FL_CAP, FL_WR, FL_DONE.
REQ-024 frame_ready sets flush_pending; frame_ready while flush_pending or flush_busy is ignored.
REQ-025 IDLE priority: flush_pending -> FL_RD (pix_cnt=0, flush_busy=1, pending cleared); else bl_write_req -> BL_WR; else bl_read_req -> BL_RD; else stay.
REQ-026 bl_write_req and bl_read_req both high: write is served first; read stays pending.
REQ-027 BL_WR (1 cycle): m9_write=1, m9_addr=bl_addr, m9_wdata={8'h00,bl_wdata}, bl_ack=1; -> IDLE.
REQ-028 BL_RD: m9_read=1, m9_addr=bl_addr; -> BL_CAP.
REQ-029 BL_CAP: bl_rdata=m9_rdata[23:0], bl_ack=1; -> IDLE. Read latency request-seen to ack = 3 cycles.
REQ-030 Blender requests are not acknowledged while flush_busy; they wait and are served after FL_DONE.
REQ-031 FL_RD: m9_read=1, m9_addr=pix_cnt; -> FL_CAP.
REQ-032 FL_CAP: sd_wdata={m9_rdata[23:19],m9_rdata[15:10],m9_rdata[7:3]}, sd_address=SD_BASE+2*pix_cnt (32-bit, wraps mod 2^32); -> FL_WR with sd_write=1.
REQ-033 FL_WR: sd_write, sd_wdata, sd_address stable until sd_ready; on sd_ready: pix_cnt==NUM_PIXELS-1 -> FL_DONE, else pix_cnt+1 -> FL_RD.
REQ-034 FL_DONE: flush_done=1 for one cycle, flush_busy cleared at exit; -> IDLE.
REQ-035 m9_read and m9_write never high in the same cycle; strobes low in every state not listed above.

Reset
REQ-036 rst high, any state: state=IDLE, pix_cnt=0, flush_pending=0, every output 0, within the same cycle (asynchronous).
REQ-037 Reset mid-flush abandons the flush; no flush_done; new frame_ready required.
REQ-038 Reset mid-access: no bl_ack; blender re-request served normally after rst falls.

Verification
REQ-039 Write bl_addr=8'h05, bl_wdata=24'hFF8040 -> next cycle m9_write=1, m9_addr=5, m9_wdata=32'h00FF8040, bl_ack=1 for 1 cycle.
REQ-040 Read addr 5 with m9_rdata=32'h00FF8040 -> bl_ack 3 cycles after request, bl_rdata=24'hFF8040.
REQ-041 NUM_PIXELS=4, sd_ready tied 1, frame_ready pulse -> 4 SD writes, addresses 0,2,4,6; pixel 24'hFF8040 gives sd_wdata=16'hFC08; flush_done once.
REQ-042 Flush with sd_ready low 5 cycles on pixel 1 -> sd_write/sd_wdata/sd_address held constant 5 cycles; no pixel skipped or repeated.
REQ-043 frame_ready and bl_write_req same cycle -> flush runs first; write acked after flush_done; second frame_ready mid-flush ignored.
REQ-044 rst asserted in FL_WR -> all outputs 0 immediately; after release, no SD writes until next frame_ready.
